// File: rtl/lane_shift_pipe.sv
// lane_shift_pipe
//   Two-stage pipelined lane shifter. A beat of LANES lanes, each LANE_W bits
//   wide, is moved by a whole number of lanes. There are four modes: shift-left
//   with fill, shift-right with fill, rotate-left and rotate-right. Beats with
//   an illegal shift amount are flagged, and a saturating counter records them.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst        : synchronous active-high reset, clears both stages and the counter
//   in_valid   : input beat valid
//   in_ready   : block can accept a beat this cycle
//   in_data    : input lanes, lane 0 = bits [LANE_W-1:0]
//   in_fill    : value written into vacated lanes in the fill modes
//   in_shift   : shift amount in lanes
//   in_mode    : 00 SHL, 01 SHR, 10 ROL, 11 ROR
//   out_valid  : output beat valid
//   out_ready  : downstream accepts the output beat
//   out_data   : shifted result
//   out_err    : the beat carried an illegal shift amount
//   err_count  : number of accepted illegal beats, saturating at all-ones

module lane_shift_pipe #(
  parameter int LANE_W    = 12,
  parameter int LANES     = 8,
  parameter int SHIFT_W   = 3,
  parameter int MAX_SHIFT = 5,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*LANE_W-1:0]   in_data,
  input  logic [LANE_W-1:0]         in_fill,
  input  logic [SHIFT_W-1:0]        in_shift,
  input  logic [1:0]                in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*LANE_W-1:0]   out_data,
  output logic                      out_err,
  output logic [CNT_W-1:0]          err_count
);

  localparam int DW = LANES * LANE_W;

  localparam logic [1:0] MODE_SHL = 2'b00;
  localparam logic [1:0] MODE_SHR = 2'b01;
  localparam logic [1:0] MODE_ROL = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  logic                 s1Valid_q;
  logic                 s1Err_q;
  logic [DW-1:0]        s1Data_q;
  logic [LANE_W-1:0]    s1Fill_q;
  logic [SHIFT_W-1:0]   s1Shift_q;
  logic [1:0]           s1Mode_q;

  logic                 s2Valid_q;
  logic                 s2Err_q;
  logic [DW-1:0]        s2Data_q;

  logic [CNT_W-1:0]     errCount_q;
  logic [CNT_W-1:0]     errCount_d;

  logic                 s1Load;
  logic                 s2Load;
  logic                 inFire;
  logic                 inErr;
  logic [DW-1:0]        shiftData_d;

  // Handshake. Stage 2 may take a new beat when it is empty or its beat is
  // leaving. Stage 1 may take a new beat when it is empty or its beat is moving
  // into stage 2. Because of this chain, a full stall holds both stages and
  // back-pressures the front-end. With no stall, one beat can move per cycle.
  always_comb begin
    s2Load = !s2Valid_q || out_ready;
    s1Load = !s1Valid_q || s2Load;
    inFire = in_valid && s1Load;
  end

  assign in_ready  = s1Load;
  assign out_valid = s2Valid_q;
  assign out_data  = s2Data_q;
  assign out_err   = s2Err_q;
  assign err_count = errCount_q;

  // The legality check is decoded from the live inputs. It only matters in the
  // cycle the beat is captured. The fill modes have their own limit, MAX_SHIFT.
  // The rotate modes are legal for any amount below LANES.
  always_comb begin
    inErr = 1'b0;
    case (in_mode)
      MODE_SHL, MODE_SHR: inErr = int'(in_shift) > MAX_SHIFT;
      default:            inErr = int'(in_shift) >= LANES;
    endcase
  end

  // The error counter steps when an illegal beat is captured into stage 1.
  // It stops at all-ones and does not wrap.
  always_comb begin
    errCount_d = errCount_q;
    if (inFire && inErr && (errCount_q != {CNT_W{1'b1}})) begin
      errCount_d = errCount_q + 1'b1;
    end
  end

  // This is the lane mover. It works on the captured stage-1 fields, and each
  // output lane picks its source lane. An illegal fill-mode beat becomes all
  // fill lanes. An illegal rotate beat passes through unchanged, so a rotate
  // source index only wraps once.
  always_comb begin
    int k;
    int src;
    shiftData_d = s1Data_q;
    k   = int'(s1Shift_q);
    src = 0;
    for (int i = 0; i < LANES; i++) begin
      case (s1Mode_q)
        MODE_SHL: begin
          if (s1Err_q || (i < k)) begin
            shiftData_d[i*LANE_W +: LANE_W] = s1Fill_q;
          end else begin
            shiftData_d[i*LANE_W +: LANE_W] = s1Data_q[(i-k)*LANE_W +: LANE_W];
          end
        end
        MODE_SHR: begin
          if (s1Err_q || (i + k >= LANES)) begin
            shiftData_d[i*LANE_W +: LANE_W] = s1Fill_q;
          end else begin
            shiftData_d[i*LANE_W +: LANE_W] = s1Data_q[(i+k)*LANE_W +: LANE_W];
          end
        end
        MODE_ROL: begin
          if (!s1Err_q) begin
            src = i - k;
            if (src < 0) begin
              src = src + LANES;
            end
            shiftData_d[i*LANE_W +: LANE_W] = s1Data_q[src*LANE_W +: LANE_W];
          end
        end
        default: begin
          if (!s1Err_q) begin
            src = i + k;
            if (src >= LANES) begin
              src = src - LANES;
            end
            shiftData_d[i*LANE_W +: LANE_W] = s1Data_q[src*LANE_W +: LANE_W];
          end
        end
      endcase
    end
  end

  // Pipeline registers. A reset empties both stages and clears the outputs and
  // the counter. Any beat in flight is lost. The data fields only update when a
  // real beat moves in, so a stalled output stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q  <= 1'b0;
      s1Err_q    <= 1'b0;
      s1Data_q   <= '0;
      s1Fill_q   <= '0;
      s1Shift_q  <= '0;
      s1Mode_q   <= MODE_SHL;
      s2Valid_q  <= 1'b0;
      s2Err_q    <= 1'b0;
      s2Data_q   <= '0;
      errCount_q <= '0;
    end else begin
      if (s1Load) begin
        s1Valid_q <= in_valid;
        if (in_valid) begin
          s1Data_q  <= in_data;
          s1Fill_q  <= in_fill;
          s1Shift_q <= in_shift;
          s1Mode_q  <= in_mode;
          s1Err_q   <= inErr;
        end
      end
      if (s2Load) begin
        s2Valid_q <= s1Valid_q;
        if (s1Valid_q) begin
          s2Data_q <= shiftData_d;
          s2Err_q  <= s1Err_q;
        end
      end
      errCount_q <= errCount_d;
    end
  end

endmodule

// File: tb/tb_lane_shift_pipe.sv
// tb_lane_shift_pipe
//   Self-checking bench for lane_shift_pipe. The bench has a scoreboard queue.
//   Each accepted beat gets its expected {err, data} from a lane-array model of
//   the shift rules. The bench also models the error counter and the
//   ready/valid behaviour from pipeline occupancy. The counter is built 4 bits
//   wide so that saturation is reachable.

module tb_lane_shift_pipe;

  localparam int LW = 12;
  localparam int NL = 8;
  localparam int SW = 3;
  localparam int MS = 5;
  localparam int CW = 4;
  localparam int DW = NL * LW;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [LW-1:0]   in_fill;
  logic [SW-1:0]   in_shift;
  logic [1:0]      in_mode;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_err;
  logic [CW-1:0]   err_count;

  int              checks;
  int              errors;
  logic [DW:0]     expQ[$];
  int              modelCnt;
  logic            heldValid;
  logic [DW+1:0]   heldWord;
  logic            lastAccepted;
  logic            lastOutValid;
  logic            lastInReady;

  lane_shift_pipe #(
    .LANE_W(LW), .LANES(NL), .SHIFT_W(SW), .MAX_SHIFT(MS), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_fill(in_fill), .in_shift(in_shift), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .err_count(err_count)
  );

  // The clock has a 10-unit period. Inputs change on the falling edge.
  // Outputs are sampled 1 unit later, well away from the rising edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // This is the single comparison point. It counts the check and reports any
  // difference.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference model: a beat is unpacked into a lane array. Each source lane is
  // placed where the mode sends it, starting from an all-fill result.
  // Bit DW of the return value is the error flag.
  function automatic logic [DW:0] refBeat(input logic [DW-1:0] d, input logic [LW-1:0] f,
                                          input logic [SW-1:0] s, input logic [1:0] m);
    logic [LW-1:0] srcL[NL];
    logic [LW-1:0] dstL[NL];
    logic [DW-1:0] res;
    logic          err;
    int            k;
    k   = int'(s);
    err = 1'b0;
    for (int j = 0; j < NL; j++) begin
      srcL[j] = d[j*LW +: LW];
      dstL[j] = f;
    end
    case (m)
      2'd0: if (k > MS) err = 1'b1;
            else for (int j = 0; j + k < NL; j++) dstL[j+k] = srcL[j];
      2'd1: if (k > MS) err = 1'b1;
            else for (int j = k; j < NL; j++) dstL[j-k] = srcL[j];
      2'd2: if (k >= NL) begin err = 1'b1; dstL = srcL; end
            else for (int j = 0; j < NL; j++) dstL[(j+k)%NL] = srcL[j];
      default: if (k >= NL) begin err = 1'b1; dstL = srcL; end
            else for (int j = 0; j < NL; j++) dstL[(j-k+NL)%NL] = srcL[j];
    endcase
    for (int j = 0; j < NL; j++) res[j*LW +: LW] = dstL[j];
    return {err, res};
  endfunction

  function automatic logic [DW-1:0] mkData(input int b);
    logic [DW-1:0] d;
    for (int j = 0; j < NL; j++) d[j*LW +: LW] = LW'(b * 16 + j);
    return d;
  endfunction

  // Runs one cycle. The inputs are already set at the falling edge. The task
  // samples and checks the outputs, and updates the model for the coming
  // rising edge. It then waits for the next falling edge.
  task automatic applyStimulus();
    #1;
    lastAccepted = 1'b0;
    lastOutValid = out_valid;
    lastInReady  = in_ready;
    if (!rst) begin
      checkOutput("inReady", 128'(in_ready), 128'((expQ.size() < 2) || out_ready));
      checkOutput("errCount", 128'(err_count), 128'(modelCnt));
      if (expQ.size() == 0) checkOutput("idleValid", 128'(out_valid), 128'(0));
      if (heldValid) checkOutput("holdData", 128'({out_valid, out_err, out_data}), 128'(heldWord));
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) checkOutput("spurious", 128'(1), 128'(0));
        else checkOutput("data", 128'({out_err, out_data}), 128'(expQ.pop_front()));
      end
      heldValid = out_valid && !out_ready;
      heldWord  = {out_valid, out_err, out_data};
      if (in_valid && in_ready) begin
        logic [DW:0] e;
        e = refBeat(in_data, in_fill, in_shift, in_mode);
        expQ.push_back(e);
        lastAccepted = 1'b1;
        if (e[DW] && modelCnt < (1 << CW) - 1) modelCnt++;
      end
    end else begin
      expQ.delete();
      modelCnt  = 0;
      heldValid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && expQ.size() > 0; c++) applyStimulus();
    checkOutput("drain", 128'(expQ.size()), 128'(0));
  endtask

  // Sends a single beat into an empty pipe. Its output must appear on the
  // second sample after the accept.
  task automatic sendOne(input logic [DW-1:0] d, input logic [LW-1:0] f,
                         input logic [SW-1:0] s, input logic [1:0] m);
    in_valid = 1'b1; in_data = d; in_fill = f; in_shift = s; in_mode = m;
    out_ready = 1'b1;
    applyStimulus();
    checkOutput("accept", 128'(lastAccepted), 128'(1));
    in_valid = 1'b0;
    in_data  = '0;
    applyStimulus();
    checkOutput("lat1", 128'(lastOutValid), 128'(0));
    applyStimulus();
    checkOutput("lat2", 128'(lastOutValid), 128'(1));
    applyStimulus();
  endtask

  initial begin
    logic [DW-1:0] base;
    int            sent;
    logic          sawStall;
    checks = 0; errors = 0; modelCnt = 0; heldValid = 1'b0; heldWord = '0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_fill = '0; in_shift = '0;
    in_mode = 2'd0; out_ready = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 3; c++) applyStimulus();
    rst = 1'b0;
    checkOutput("rstState", 128'({out_valid, out_err, out_data, err_count}), 128'(0));
    applyStimulus();

    // Directed beats.
    base = 96'h008_007_006_005_004_003_002_001;
    sendOne(base, 12'hABC, 3'd2, 2'd0);
    sendOne(base, 12'hFFF, 3'd3, 2'd1);
    sendOne(base, 12'h000, 3'd7, 2'd2);
    sendOne(base, 12'h000, 3'd1, 2'd3);
    sendOne(base, 12'h555, 3'd0, 2'd1);
    sendOne(base, 12'h123, 3'd6, 2'd0);
    checkOutput("errCnt1", 128'(err_count), 128'(1));
    sendOne(base, 12'h123, 3'd5, 2'd0);
    checkOutput("errCnt1b", 128'(err_count), 128'(1));

    // Ten beats back to back, with the downstream stalled for cycles 3 to 6.
    sent = 0; sawStall = 1'b0;
    for (int c = 0; c < 40 && sent < 10; c++) begin
      in_valid = 1'b1; in_data = mkData(sent); in_fill = 12'h0;
      in_shift = SW'(sent); in_mode = 2'(sent % 4);
      out_ready = !(c >= 3 && c <= 6);
      applyStimulus();
      if (lastAccepted) sent++;
      if (!lastInReady) sawStall = 1'b1;
    end
    checkOutput("stallSent", 128'(sent), 128'(10));
    checkOutput("stallSeen", 128'(sawStall), 128'(1));
    drain();

    // Illegal beats drive the counter into saturation.
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1; in_data = mkData(c + 20); in_fill = 12'h3C3;
      in_shift = 3'd7; in_mode = 2'(c % 2);
      out_ready = 1'b1;
      applyStimulus();
    end
    drain();
    checkOutput("satCount", 128'(err_count), 128'(4'hF));

    // Random traffic with back-pressure, and a reset in the middle of it.
    for (int c = 0; c < 400; c++) begin
      rst       = (c == 150);
      in_valid  = ($urandom % 4) != 0;
      in_data   = {$urandom, $urandom, $urandom};
      in_fill   = LW'($urandom);
      in_shift  = SW'($urandom);
      in_mode   = 2'($urandom);
      out_ready = ($urandom % 4) != 0;
      if (c == 151) checkOutput("rstData", 128'({out_valid, out_err, out_data, err_count}), 128'(0));
      applyStimulus();
    end
    rst = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lane_shift_pipe.md
Name: lane_shift_pipe

Overview:
- Pipelined, parametrised successor to the combinational 8×12-bit lane left-shifter.
- Moves a vector of LANES lanes of LANE_W bits by a whole-lane count.
- Four modes: shift-left with fill, shift-right with fill, rotate-left, rotate-right.
- Registered two-stage datapath with valid/ready handshake, per-beat error flag and saturating error counter. Sits between lane-packing front-end and downstream aligner.

Parameters:
- LANE_W, 12, bits per lane.
- LANES, 8, number of lanes; data width = LANES*LANE_W.
- SHIFT_W, 3, width of shift amount; must satisfy 2**SHIFT_W >= LANES.
- MAX_SHIFT, 5, largest legal shift for fill modes (0..LANES-1).
- CNT_W, 16, error counter width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept beat this cycle.
- in_data  in  LANES*LANE_W  lane 0 = bits [LANE_W-1:0].
- in_fill  in  LANE_W  value inserted into vacated lanes (fill modes).
- in_shift  in  SHIFT_W  lane count.
- in_mode  in  2  00 SHL, 01 SHR, 10 ROL, 11 ROR.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  LANES*LANE_W  result.
- out_err  out  1  beat had illegal shift.
- err_count  out  CNT_W  accepted illegal beats, saturating.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_err=0, err_count=0; in_ready=1 the cycle after reset deasserts. Reset mid-transfer discards both stages; no beat emitted.
- Handshake: input transfer when in_valid&in_ready; output transfer when out_valid&out_ready. out_data/out_err are held stable while out_valid&!out_ready.
- Pipeline:
  - Stage 1 captures data, fill, shift, mode and computes err.
  - Stage 2 captures the shifted result.
  - s2_load = !s2_valid | out_ready. s1_load = !s1_valid | s2_load. in_ready = s1_load.
  - Latency: 2 cycles from accept to out_valid with no backpressure; throughput 1 beat/cycle.
  - Full stall holds both stages; no beat lost or duplicated.
- Modes, k = shift:
  - SHL: out lane i = in lane i-k for i>=k, else fill.
  - SHR: out lane i = in lane i+k for i+k<LANES, else fill.
  - ROL: out lane i = in lane (i-k) mod LANES.
  - ROR: out lane i = in lane (i+k) mod LANES.
- k=0 passes data unchanged in all modes.
- Error rule:
  - In SHL/SHR, k>MAX_SHIFT sets err=1 and forces all output lanes to fill.
  - In ROL/ROR, k>=LANES sets err=1 and passes data unchanged.
  - Otherwise err=0.
- err_count increments by 1 at stage-1 capture of an err beat, saturates at all-ones. A simultaneous reset wins.
- Shift values are decoded only at capture; changes on in_* while !in_ready have no effect.

Test Plan:
- Reset, then SHL k=2, fill=0xABC, in lanes 0..7 = 0x001..0x008, out_ready=1 -> 2 cycles later out lanes = ABC,ABC,001,002,003,004,005,006; out_err=0.
- SHR k=3, same data, fill=0xFFF -> lanes = 004,005,006,007,008,FFF,FFF,FFF.
- ROL k=7 -> lanes = 002,003,004,005,006,007,008,001; ROR k=1 gives the same result; err=0 for both.
- SHL k=6, fill=0x123 -> all lanes 0x123, out_err=1, err_count 0->1; then SHL k=5 legal -> err=0, count stays 1.
- Back-to-back 10 beats with out_ready low for cycles 3-6 -> in_ready low after both stages fill; all 10 beats emerge in order, none duplicated.
- Force err_count to saturation via 2**CNT_W illegal beats (or CNT_W=4 build, 20 beats) -> holds 0xF; assert rst mid-stream -> out_valid=0 and err_count=0 next cycle.
